// File: rtl/embedded_computer_system_cpu_cpu_debug_ocimem_pkg.sv
// Shared definitions for the Nios II OCI debug memory block.
//   - FSM state encoding (RMW state only exists with OCIMEM_PARITY_EN)
//   - jdo field positions used by the JTAG strobes
//   - register window word offsets
//   - byte-lane merge and parity helpers
package embedded_computer_system_cpu_cpu_debug_pkg;

  localparam int OCI_AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    J_RD,
    J_RD_DATA,
    J_WR
`ifdef OCIMEM_PARITY_EN
    , RMW
`endif
  } state_e;

  // jdo field positions
  localparam int JDO_RD_EN   = 35;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_ADDR_HI = 17;
  localparam int JDO_ADDR_LO = 9;

  // register window word offsets (address bit 8 = 1)
  localparam logic [7:0] REG_CFG_ID  = 8'd0;
  localparam logic [7:0] REG_MONAREG = 8'd1;
  localparam logic [7:0] REG_BUSY    = 8'd2;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/embedded_computer_system_cpu_cpu_debug_ocimem_if.sv
// Avalon-MM debug_mem slave bus between the CPU and the OCI memory.
//   master: address, byteenable, debugaccess, read, write, writedata -> ;
//           <- readdata, waitrequest
//   slave : the mirror image
interface embedded_computer_system_cpu_cpu_debug_ocimem_if;
  logic [8:0]  address;
  logic [3:0]  byteenable;
  logic        debugaccess;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, byteenable, debugaccess, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, byteenable, debugaccess, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/embedded_computer_system_cpu_cpu_ociram_sp_ram.sv
// Single-port OCI RAM, synchronous read (1-cycle latency), byte-lane writes.
// Contents are not reset.  With OCIMEM_PARITY_EN each word carries an extra
// parity bit (bit 32), written on every write; the caller only issues
// full-word writes in that build.
// Ports: clk, addr, we, be, wdata, rdata (+ wpar, rpar with OCIMEM_PARITY_EN)
module embedded_computer_system_cpu_cpu_ociram_sp_ram #(
  parameter int RAM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
`ifdef OCIMEM_PARITY_EN
  input  logic          wpar,
  output logic          rpar,
`endif
  output logic [31:0]   rdata
);
`ifdef OCIMEM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  logic [MW-1:0] mem [RAM_WORDS];
  logic [MW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
`ifdef OCIMEM_PARITY_EN
      mem[addr][32] <= wpar;
`endif
    end
    rd_q <= mem[addr];
  end

  assign rdata = rd_q[31:0];
`ifdef OCIMEM_PARITY_EN
  assign rpar = rd_q[32];
`endif
endmodule

// File: rtl/embedded_computer_system_cpu_cpu_debug_ocimem.sv
// OCI debug memory: 256x32 RAM shared by the CPU debug_mem Avalon slave and
// the JTAG debug slave, plus a read-only register window at 0x100-0x1FF.
// Ports:
//   clk, reset_n (async, active-low)
//   avs                 : CPU Avalon slave (interface, slave modport)
//   jdo, take_*         : JTAG data and single-cycle command strobes
//   MonDReg / MonAReg   : JTAG data / word-address registers
//   jtag_busy           : a JTAG access is pending or in flight
//   ociram_parity_err   : sticky parity error
// Optional feature macro: OCIMEM_PARITY_EN (33-bit RAM with even parity,
// read-modify-write for partial CPU writes, sticky error flag).
module embedded_computer_system_cpu_cpu_debug_ocimem
  import embedded_computer_system_cpu_cpu_debug_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] CFG_ID    = 32'h0000_0022
) (
  input  logic        clk,
  input  logic        reset_n,
  embedded_computer_system_cpu_cpu_debug_ocimem_if.slave avs,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic [8:0]  MonAReg,
  output logic        jtag_busy,
  output logic        ociram_parity_err
);

  state_e      state_q, state_d;
  logic [31:0] mon_d_q, mon_d_d;
  logic [8:0]  mon_a_q, mon_a_d;
  logic        busy_q, busy_d;
  logic        jrd_pend_q, jrd_pend_d;
  logic        jwr_pend_q, jwr_pend_d;
  logic        rd_phase_q, rd_phase_d;
  logic        rst_hold_q, rst_hold_d;
  logic [31:0] readdata_q, readdata_d;

  logic [OCI_AW-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              par_chk;
  logic              cpu_ack;
  logic              cpu_req;
  logic              cpu_wr_ok;
  logic              needs_rmw;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  function automatic logic [31:0] win_read(input logic [7:0] off,
                                           input logic [8:0] areg,
                                           input logic       busy);
    case (off)
      REG_CFG_ID:  return CFG_ID;
      REG_MONAREG: return {23'b0, areg};
      REG_BUSY:    return {31'b0, busy};
      default:     return 32'b0;
    endcase
  endfunction

  assign cpu_req   = avs.read | avs.write;
  // Writes to RAM need debugaccess; window writes are always discarded.
  assign cpu_wr_ok = avs.write & ~avs.address[8] & avs.debugaccess;
`ifdef OCIMEM_PARITY_EN
  // Partial writes need the old word to compute parity over the merged data.
  assign needs_rmw = cpu_wr_ok & (avs.byteenable != 4'hF);
`else
  assign needs_rmw = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mon_d_d    = mon_d_q;
    mon_a_d    = mon_a_q;
    busy_d     = busy_q;
    jrd_pend_d = jrd_pend_q;
    jwr_pend_d = jwr_pend_q;
    rd_phase_d = rd_phase_q;
    rst_hold_d = 1'b0;
    readdata_d = readdata_q;
    // RAM follows the CPU address by default so a CPU read has data ready
    // one cycle after leaving IDLE.
    ram_addr   = avs.address[OCI_AW-1:0];
    ram_we     = 1'b0;
    ram_be     = 4'hF;
    ram_wdata  = avs.writedata;
    par_chk    = 1'b0;
    cpu_ack    = 1'b0;

    // JTAG strobes are only accepted while no JTAG access is outstanding.
    if (!busy_q) begin
      if (take_action_ocimem_a) begin
        mon_a_d = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
        if (jdo[JDO_RD_EN]) begin
          jrd_pend_d = 1'b1;
          busy_d     = 1'b1;
        end
      end else if (take_no_action_ocimem_a) begin
        mon_a_d    = mon_a_q + 9'd1;
        jrd_pend_d = 1'b1;
        busy_d     = 1'b1;
      end else if (take_action_ocimem_b) begin
        mon_d_d    = jdo[JDO_DATA_HI:JDO_DATA_LO];
        jwr_pend_d = 1'b1;
        busy_d     = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        rd_phase_d = 1'b0;
        if (cpu_req) begin
          state_d = CPU_ACC;
        end else if (jrd_pend_q) begin
          state_d    = J_RD;
          jrd_pend_d = 1'b0;
        end else if (jwr_pend_q) begin
          state_d    = J_WR;
          jwr_pend_d = 1'b0;
        end
      end
      CPU_ACC: begin
        if (avs.write) begin
          if (needs_rmw) begin
`ifdef OCIMEM_PARITY_EN
            state_d = RMW;
`endif
          end else begin
            ram_we    = cpu_wr_ok;
            ram_be    = avs.byteenable;
            cpu_ack   = 1'b1;
            state_d   = IDLE;
          end
        end else if (avs.read) begin
          if (!rd_phase_q) begin
            readdata_d = avs.address[8] ? win_read(avs.address[7:0], mon_a_q, busy_q)
                                        : ram_rdata;
            par_chk    = ~avs.address[8];
            rd_phase_d = 1'b1;
          end else begin
            cpu_ack    = 1'b1;
            rd_phase_d = 1'b0;
            state_d    = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef OCIMEM_PARITY_EN
      RMW: begin
        ram_we    = 1'b1;
        ram_wdata = merge_bytes(ram_rdata, avs.writedata, avs.byteenable);
        par_chk   = 1'b1;
        cpu_ack   = 1'b1;
        state_d   = IDLE;
      end
`endif
      J_RD: begin
        ram_addr = mon_a_q[OCI_AW-1:0];
        state_d  = J_RD_DATA;
      end
      J_RD_DATA: begin
        mon_d_d = mon_a_q[8] ? win_read(mon_a_q[7:0], mon_a_q, busy_q) : ram_rdata;
        par_chk = ~mon_a_q[8];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      J_WR: begin
        ram_addr  = mon_a_q[OCI_AW-1:0];
        ram_we    = ~mon_a_q[8];
        ram_wdata = mon_d_q;
        mon_a_d   = mon_a_q + 9'd1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef OCIMEM_PARITY_EN
  logic ram_rpar;
  logic par_err_q, par_err_d;
  always_comb begin
    par_err_d = par_err_q | (par_chk & (ram_rpar ^ even_par(ram_rdata)));
  end
`else
  logic unused_par;
  assign unused_par = par_chk;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mon_d_q    <= '0;
      mon_a_q    <= '0;
      busy_q     <= 1'b0;
      jrd_pend_q <= 1'b0;
      jwr_pend_q <= 1'b0;
      rd_phase_q <= 1'b0;
      rst_hold_q <= 1'b1;
      readdata_q <= '0;
`ifdef OCIMEM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mon_d_q    <= mon_d_d;
      mon_a_q    <= mon_a_d;
      busy_q     <= busy_d;
      jrd_pend_q <= jrd_pend_d;
      jwr_pend_q <= jwr_pend_d;
      rd_phase_q <= rd_phase_d;
      rst_hold_q <= rst_hold_d;
      readdata_q <= readdata_d;
`ifdef OCIMEM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  embedded_computer_system_cpu_cpu_ociram_sp_ram #(
    .RAM_WORDS (RAM_WORDS),
    .AW        (OCI_AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
`ifdef OCIMEM_PARITY_EN
    .wpar  (even_par(ram_wdata)),
    .rpar  (ram_rpar),
`endif
    .rdata (ram_rdata)
  );

  // Held high through reset and the first clock after it; otherwise only a
  // CPU request that is not being acknowledged this cycle waits.
  assign avs.waitrequest = rst_hold_q | (cpu_req & ~cpu_ack);
  assign avs.readdata    = readdata_q;
  assign MonDReg         = mon_d_q;
  assign MonAReg         = mon_a_q;
  assign jtag_busy       = busy_q;
`ifdef OCIMEM_PARITY_EN
  assign ociram_parity_err = par_err_q;
`else
  assign ociram_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_embedded_computer_system_cpu_cpu_debug_ocimem.sv
module tb_embedded_computer_system_cpu_cpu_debug_ocimem;
  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic [8:0]  MonAReg;
  logic        jtag_busy;
  logic        ociram_parity_err;

  embedded_computer_system_cpu_cpu_debug_ocimem_if bus ();

  embedded_computer_system_cpu_cpu_debug_ocimem dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .avs                     (bus),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .jtag_busy               (jtag_busy),
    .ociram_parity_err       (ociram_parity_err)
  );

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
    logic [8:0]  areg;
  } jexp_t;

  logic [31:0] cpu_q [$];
  jexp_t       jq [$];
  int          checks   = 0;
  int          failures = 0;
  time         cpu_t    = 0;
  time         jtag_t   = 0;
  logic        busy_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT completes a CPU read or a
  // JTAG access.
  initial begin
    jexp_t j;
    logic [31:0] e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.read && !bus.waitrequest) begin
          if (cpu_q.size() == 0) check32("cpu_rd_unexpected", 32'd1, 32'd0);
          else begin
            e = cpu_q.pop_front();
            check32("cpu_readdata", bus.readdata, e);
            cpu_t = $time;
          end
        end
        if (busy_prev && !jtag_busy) begin
          if (jq.size() == 0) check32("jtag_unexpected", 32'd1, 32'd0);
          else begin
            j = jq.pop_front();
            if (j.is_rd) check32("jtag_mondreg", MonDReg, j.data);
            check32("jtag_monareg", {23'b0, MonAReg}, {23'b0, j.areg});
            jtag_t = $time;
          end
        end
      end
      busy_prev = jtag_busy;
    end
  end

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, output int n);
    bus.address = a; bus.writedata = d; bus.byteenable = be;
    bus.debugaccess = dbg; bus.write = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.waitrequest && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) check32("cpu_wr_timeout", 32'd1, 32'd0);
    tick();
    bus.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [8:0] a, input logic [31:0] exp, output int n);
    cpu_q.push_back(exp);
    bus.address = a; bus.read = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.waitrequest && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) check32("cpu_rd_timeout", 32'd1, 32'd0);
    tick();
    bus.read = 1'b0;
  endtask

  task automatic jtag_a(input logic [8:0] a, input logic rd);
    jdo = '0; jdo[35] = rd; jdo[17:9] = a;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_noact();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_jtag_idle();
    int n = 0;
    while ((jtag_busy || jq.size() != 0) && n < 50) begin tick(); n++; end
    if (n >= 50) check32("jtag_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.address = '0; bus.byteenable = 4'hF; bus.debugaccess = 1'b0;
    bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    jdo = '0; take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check32("rst_mondreg", MonDReg, 0);
    check32("rst_monareg", {23'b0, MonAReg}, 0);
    check32("rst_readdata", bus.readdata, 0);
    check32("rst_waitreq", {31'b0, bus.waitrequest}, 1);
    check32("rst_busy", {31'b0, jtag_busy}, 0);
    check32("rst_perr", {31'b0, ociram_parity_err}, 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check32("rel_waitreq_hold", {31'b0, bus.waitrequest}, 1);
    tick();
    check32("rel_waitreq_drop", {31'b0, bus.waitrequest}, 0);

    // JTAG load-and-read, with latency from strobe to busy release
    cpu_write(9'h010, 32'hDEAD_BEEF, 4'hF, 1'b1, n);
    jq.push_back('{is_rd: 1'b1, data: 32'hDEAD_BEEF, areg: 9'h010});
    jtag_a(9'h010, 1'b1);
    n = 0;
    @(negedge clk);
    while (jtag_busy && n < 20) begin n++; @(negedge clk); end
    check32("jtag_rd_busy_cycles", n, 3);
    tick();
    wait_jtag_idle();

    // JTAG write stream
    jtag_a(9'h020, 1'b0);
    check32("monareg_load", {23'b0, MonAReg}, 32'h020);
    for (int i = 1; i <= 3; i++) begin
      jq.push_back('{is_rd: 1'b0, data: 32'(i), areg: 9'(9'h020 + i)});
      jtag_b(32'(i));
      wait_jtag_idle();
    end
    cpu_read(9'h020, 32'd1, n);
    check32("cpu_rd_wait_cycles", n, 2);
    cpu_read(9'h021, 32'd2, n);
    cpu_read(9'h022, 32'd3, n);
    check32("stream_monareg_end", {23'b0, MonAReg}, 32'h023);

    // Protection and byte lanes
    cpu_write(9'h005, 32'hCAFE_F00D, 4'hF, 1'b1, n);
    cpu_write(9'h005, 32'h1234_5678, 4'hF, 1'b0, n);
    check32("prot_wr_wait_cycles", n, 1);
    cpu_read(9'h005, 32'hCAFE_F00D, n);
    cpu_write(9'h005, 32'h0000_AB00, 4'b0010, 1'b1, n);
    cpu_read(9'h005, 32'hCAFE_AB0D, n);

    // Address wrap
    cpu_write(9'h000, 32'h0BAD_F00D, 4'hF, 1'b1, n);
    jtag_a(9'h1FF, 1'b0);
    check32("wrap_monareg_pre", {23'b0, MonAReg}, 32'h1FF);
    jq.push_back('{is_rd: 1'b1, data: 32'h0BAD_F00D, areg: 9'h000});
    jtag_noact();
    wait_jtag_idle();

    // Collision: CPU wins, second strobe while busy is dropped
    jq.push_back('{is_rd: 1'b1, data: 32'd1, areg: 9'h020});
    fork
      cpu_read(9'h010, 32'hDEAD_BEEF, n);
      begin
        jtag_a(9'h020, 1'b1);
        jtag_a(9'h030, 1'b1);
      end
    join
    wait_jtag_idle();
    check32("collision_order", {31'b0, (cpu_t < jtag_t)}, 1);

    // Register window
    cpu_read(9'h100, 32'h0000_0022, n);
    cpu_write(9'h100, 32'hFFFF_FFFF, 4'hF, 1'b1, n);
    cpu_read(9'h100, 32'h0000_0022, n);
    cpu_read(9'h101, 32'h0000_0020, n);
    cpu_read(9'h105, 32'h0000_0000, n);
    jq.push_back('{is_rd: 1'b1, data: 32'h0000_0022, areg: 9'h100});
    jtag_a(9'h100, 1'b1);
    wait_jtag_idle();
    jq.push_back('{is_rd: 1'b1, data: 32'h0000_0001, areg: 9'h102});
    jtag_a(9'h102, 1'b1);
    wait_jtag_idle();

    // Reset during J_RD
    jtag_a(9'h010, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    check32("midrst_mondreg", MonDReg, 0);
    check32("midrst_busy", {31'b0, jtag_busy}, 0);
    check32("midrst_waitreq", {31'b0, bus.waitrequest}, 1);
    check32("midrst_monareg", {23'b0, MonAReg}, 0);
    check32("midrst_readdata", bus.readdata, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check32("midrst_waitreq_drop", {31'b0, bus.waitrequest}, 0);
    cpu_read(9'h010, 32'hDEAD_BEEF, n);

`ifdef OCIMEM_PARITY_EN
    cpu_write(9'h040, 32'h0000_0001, 4'hF, 1'b1, n);
    check32("parity_err_clear", {31'b0, ociram_parity_err}, 0);
    dut.u_ram.mem[64][32] = ~dut.u_ram.mem[64][32];
    cpu_read(9'h040, 32'h0000_0001, n);
    @(negedge clk);
    check32("parity_err_set", {31'b0, ociram_parity_err}, 1);
`else
    @(negedge clk);
    check32("parity_err_tied", {31'b0, ociram_parity_err}, 0);
`endif

    repeat (3) tick();
    check32("cpu_q_empty", cpu_q.size(), 0);
    check32("jq_empty", jq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
